score_keeper: RTL



---
 rtl/score_pkg.sv | 32 +++
 rtl/score_keeper_if.sv | 33 +++
 rtl/score_round_eval.sv | 84 ++++++++
 rtl/score_keeper.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score_keeper round-scoring engine.
//   code_e   - per-channel 2-bit code (miss / hit / bonus / penalty)
//   state_e  - round FSM states
//   flags_t  - flags accumulated while scanning the channels of one round
//   PENALTY_PTS - points removed by a penalty round (only when SCORE_PENALTY_EN is defined)
package score_pkg;

    typedef enum logic [1:0] {
        CODE_MISS  = 2'd0,
        CODE_HIT   = 2'd1,
        CODE_BONUS = 2'd2,
        CODE_PEN   = 2'd3
    } code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic any_bonus;
        logic any_pen;
        logic all_hit;
    } flags_t;

    // all_hit starts true and is knocked down by any non-hit channel
    localparam flags_t FLAGS_INIT = '{any_bonus: 1'b0, any_pen: 1'b0, all_hit: 1'b1};

    localparam int unsigned PENALTY_PTS = 3;

endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: request/result bundle between the game controller and score_keeper.
//   codes      - 2*N_CH channel codes, channel i at [2i+1:2i]
//   start_calc - request a round evaluation
//   new_game   - restart score and streak, keep high_score
//   busy       - round in progress
//   done       - one-cycle pulse when score/high_score are updated
//   score, high_score, new_record, streak - round results
// master = game controller side, slave = score_keeper side.
interface score_keeper_if #(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned SCORE_W  = 11,
    parameter int unsigned STREAK_W = 4
);
    logic [2*N_CH-1:0]   codes;
    logic                start_calc;
    logic                new_game;
    logic                busy;
    logic                done;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  high_score;
    logic                new_record;
    logic [STREAK_W-1:0] streak;

    modport master (
        output codes, start_calc, new_game,
        input  busy, done, score, high_score, new_record, streak
    );

    modport slave (
        input  codes, start_calc, new_game,
        output busy, done, score, high_score, new_record, streak
    );
endinterface

// File: rtl/score_round_eval.sv
// score_round_eval: combinational round classification and scoring arithmetic.
//   flags        - accumulated any_bonus / any_pen / all_hit for the round
//   streak       - current consecutive all-hit count
//   score        - current running score
//   high_score   - current best score
//   score_next_c - score after this round (saturating / floored)
//   high_next_c  - high score after this round
//   streak_next_c- streak after this round
//   record_c     - this round raises high_score
// Class priority: penalty > bonus > all-hit > base.
module score_round_eval
    import score_pkg::*;
#(
    parameter int unsigned SCORE_W     = 11,
    parameter int unsigned STREAK_W    = 4,
    parameter int unsigned STREAK_LEN  = 3,
    parameter int unsigned BASE_PTS    = 1,
    parameter int unsigned ALL_HIT_PTS = 10,
    parameter int unsigned BONUS_PTS   = 5
) (
    input  flags_t              flags,
    input  logic [STREAK_W-1:0] streak,
    input  logic [SCORE_W-1:0]  score,
    input  logic [SCORE_W-1:0]  high_score,
    output logic [SCORE_W-1:0]  score_next_c,
    output logic [SCORE_W-1:0]  high_next_c,
    output logic [STREAK_W-1:0] streak_next_c,
    output logic                record_c
);

    localparam int unsigned SUM_W = SCORE_W + 2;
    localparam logic [SUM_W-1:0]    SCORE_MAX  = {2'b00, {SCORE_W{1'b1}}};
    localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};

    logic [STREAK_W-1:0] streak_inc;
    logic [SUM_W-1:0]    pts;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    score_ext;

    // Classify the round and compute the clamped score
    always_comb begin
        streak_inc    = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
        score_ext     = {2'b00, score};
        pts           = SUM_W'(BASE_PTS);
        sum           = '0;
        streak_next_c = '0;
        score_next_c  = score;

        if (flags.any_pen) begin
            // Floor at zero rather than wrapping
            if (score_ext >= SUM_W'(PENALTY_PTS)) begin
                sum = score_ext - SUM_W'(PENALTY_PTS);
            end else begin
                sum = '0;
            end
            score_next_c = sum[SCORE_W-1:0];
        end else begin
            if (flags.any_bonus) begin
                pts = SUM_W'(BONUS_PTS);
            end else if (flags.all_hit) begin
                streak_next_c = streak_inc;
                // Doubling uses the streak including this round
                if (32'(streak_inc) >= STREAK_LEN) begin
                    pts = SUM_W'(2 * ALL_HIT_PTS);
                end else begin
                    pts = SUM_W'(ALL_HIT_PTS);
                end
            end else begin
                pts = SUM_W'(BASE_PTS);
            end
            sum = score_ext + pts;
            if (sum > SCORE_MAX) begin
                score_next_c = SCORE_MAX[SCORE_W-1:0];
            end else begin
                score_next_c = sum[SCORE_W-1:0];
            end
        end

        // Strictly greater raises the record; penalty rounds never do
        record_c    = !flags.any_pen && (score_next_c > high_score);
        high_next_c = record_c ? score_next_c : high_score;
    end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: round-scoring engine for the Blast game.
//   clk, rst - clock and synchronous active-high reset
//   bus      - score_keeper_if slave port (codes, start_calc, new_game in;
//              busy, done, score, high_score, new_record, streak out)
// A round latches codes on start_calc in IDLE, scans one channel per cycle
// in SCAN (N_CH cycles), then updates results in COMMIT; done is visible
// N_CH+2 cycles after the start cycle.
// Optional feature: define SCORE_PENALTY_EN to make code 3 a penalty round;
// otherwise code 3 behaves as a miss.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned SCORE_W     = 11,
    parameter int unsigned INIT_SCORE  = 55,
    parameter int unsigned BASE_PTS    = 1,
    parameter int unsigned ALL_HIT_PTS = 10,
    parameter int unsigned BONUS_PTS   = 5,
    parameter int unsigned STREAK_LEN  = 3,
    parameter int unsigned STREAK_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave bus
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

    state_e              state;
    logic [2*N_CH-1:0]   shadow;
    logic [IDX_W-1:0]    idx;
    flags_t              flags;
    flags_t              flags_next_c;
    code_e               cur_code;

    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  high_score;
    logic [STREAK_W-1:0] streak;
    logic                busy;
    logic                done;
    logic                new_record;

    logic [SCORE_W-1:0]  score_next_c;
    logic [SCORE_W-1:0]  high_next_c;
    logic [STREAK_W-1:0] streak_next_c;
    logic                record_c;

    // Fold the channel under scan into the round flags
    always_comb begin
        cur_code     = code_e'(shadow[{idx, 1'b0} +: 2]);
        flags_next_c = flags;
        if (cur_code != CODE_HIT) begin
            flags_next_c.all_hit = 1'b0;
        end
        if (cur_code == CODE_BONUS) begin
            flags_next_c.any_bonus = 1'b1;
        end
`ifdef SCORE_PENALTY_EN
        if (cur_code == CODE_PEN) begin
            flags_next_c.any_pen = 1'b1;
        end
`endif
    end

    score_round_eval #(
        .SCORE_W    (SCORE_W),
        .STREAK_W   (STREAK_W),
        .STREAK_LEN (STREAK_LEN),
        .BASE_PTS   (BASE_PTS),
        .ALL_HIT_PTS(ALL_HIT_PTS),
        .BONUS_PTS  (BONUS_PTS)
    ) u_eval (
        .flags        (flags),
        .streak       (streak),
        .score        (score),
        .high_score   (high_score),
        .score_next_c (score_next_c),
        .high_next_c  (high_next_c),
        .streak_next_c(streak_next_c),
        .record_c     (record_c)
    );

    // Round FSM with registered outputs; new_game aborts from any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shadow     <= '0;
            idx        <= '0;
            flags      <= FLAGS_INIT;
            score      <= SCORE_W'(INIT_SCORE);
            high_score <= SCORE_W'(INIT_SCORE);
            streak     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            new_record <= 1'b0;
        end else begin
            done       <= 1'b0;
            new_record <= 1'b0;
            if (bus.new_game) begin
                state  <= ST_IDLE;
                score  <= SCORE_W'(INIT_SCORE);
                streak <= '0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start_calc) begin
                            shadow <= bus.codes;
                            idx    <= '0;
                            flags  <= FLAGS_INIT;
                            busy   <= 1'b1;
                            state  <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        flags <= flags_next_c;
                        idx   <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        score      <= score_next_c;
                        high_score <= high_next_c;
                        streak     <= streak_next_c;
                        new_record <= record_c;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.score      = score;
    assign bus.high_score = high_score;
    assign bus.new_record = new_record;
    assign bus.streak     = streak;

endmodule
